// File: rtl/reg_mst_rr_arb_if.sv
// Bus bundle between the register masters, the round-robin arbiter and the
// shared register-slave FSM port. Master signals are packed per master,
// master i at [i*WIDTH +: WIDTH].
interface reg_mst_rr_arb_if #(
    parameter int MST_NUM    = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
);
    // master -> arbiter
    logic [MST_NUM-1:0]            mst__arb__req_vld;
    logic [MST_NUM-1:0]            mst__arb__rd_en;
    logic [MST_NUM-1:0]            mst__arb__wr_en;
    logic [MST_NUM*ADDR_WIDTH-1:0] mst__arb__addr;
    logic [MST_NUM*DATA_WIDTH-1:0] mst__arb__wr_data;
    logic [MST_NUM-1:0]            mst__arb__ack_rdy;

    // arbiter -> master
    logic [MST_NUM-1:0]            arb__mst__req_rdy;
    logic [MST_NUM-1:0]            arb__mst__ack_vld;
    logic                          arb__mst__ack_err;
    logic [DATA_WIDTH-1:0]         arb__mst__rd_data;

    // arbiter -> slave
    logic                          arb__slv__req_vld;
    logic                          arb__slv__rd_en;
    logic                          arb__slv__wr_en;
    logic [ADDR_WIDTH-1:0]         arb__slv__addr;
    logic [DATA_WIDTH-1:0]         arb__slv__wr_data;
    logic                          arb__slv__ack_rdy;

    // slave -> arbiter
    logic                          slv__arb__req_rdy;
    logic                          slv__arb__ack_vld;
    logic [DATA_WIDTH-1:0]         slv__arb__rd_data;

    // the arbiter itself
    modport arb (
        input  mst__arb__req_vld, mst__arb__rd_en, mst__arb__wr_en,
               mst__arb__addr, mst__arb__wr_data, mst__arb__ack_rdy,
        output arb__mst__req_rdy, arb__mst__ack_vld, arb__mst__ack_err,
               arb__mst__rd_data,
        output arb__slv__req_vld, arb__slv__rd_en, arb__slv__wr_en,
               arb__slv__addr, arb__slv__wr_data, arb__slv__ack_rdy,
        input  slv__arb__req_rdy, slv__arb__ack_vld, slv__arb__rd_data
    );

    // the group of register masters
    modport master (
        output mst__arb__req_vld, mst__arb__rd_en, mst__arb__wr_en,
               mst__arb__addr, mst__arb__wr_data, mst__arb__ack_rdy,
        input  arb__mst__req_rdy, arb__mst__ack_vld, arb__mst__ack_err,
               arb__mst__rd_data
    );

    // the shared register-slave FSM
    modport slave (
        input  arb__slv__req_vld, arb__slv__rd_en, arb__slv__wr_en,
               arb__slv__addr, arb__slv__wr_data, arb__slv__ack_rdy,
        output slv__arb__req_rdy, slv__arb__ack_vld, slv__arb__rd_data
    );
endinterface

// File: rtl/reg_mst_rr_arb.sv
// Round-robin arbiter sharing one register-slave port among MST_NUM masters.
// One access is outstanding at a time: grant, forward the request, route the
// ack/read data back to the granted master, then rotate priority past it.
// A timeout forces an error ack so a hung slave cannot starve every master.
module reg_mst_rr_arb #(
    parameter int MST_NUM     = 4,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic sync_reset,
    output logic arb__slv__sync_reset,
    reg_mst_rr_arb_if.arb bus
);
    localparam int IW = $clog2(MST_NUM);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [IW-1:0] MST_LAST = IW'(MST_NUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_TMO} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gnt;
    logic [IW-1:0]         winner;
    logic                  any_req;
    int                    scan_idx;
    logic [TW-1:0]         tmo_cnt;
    logic                  lat_rd_en;
    logic                  lat_wr_en;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wr_data;
    logic                  accept;
    logic                  done;
    logic                  tmo_hit;
    logic                  ack_path;
    logic                  busy;
    logic                  ack_rdy_gnt;

    assign arb__slv__sync_reset = sync_reset;

    // Pick the first requesting master scanning upward from the priority pointer.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < MST_NUM; k++) begin
            scan_idx = (int'(ptr) + k) % MST_NUM;
            if (!any_req && bus.mst__arb__req_vld[scan_idx]) begin
                any_req = 1'b1;
                winner  = IW'(scan_idx);
            end
        end
    end

    // Handshake qualifiers; a slave ack seen while still in S_REQ is honoured as if in S_ACK.
    always_comb begin
        busy        = (state == S_REQ) || (state == S_ACK);
        ack_rdy_gnt = bus.mst__arb__ack_rdy[gnt];
        accept      = (state == S_IDLE) && any_req && !sync_reset;
        ack_path    = (state == S_ACK) || ((state == S_REQ) && bus.slv__arb__ack_vld);
        tmo_hit     = (TIMEOUT_CYC != 0) && busy && (tmo_cnt == TMO_LAST) && !bus.slv__arb__ack_vld;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; done marks a completed access so the pointer can rotate.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.slv__arb__ack_vld && ack_rdy_gnt) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = S_TMO;
                end else if (bus.slv__arb__req_rdy || bus.slv__arb__ack_vld) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (bus.slv__arb__ack_vld && ack_rdy_gnt) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = S_TMO;
                end
            end
            S_TMO: begin
                if (ack_rdy_gnt) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (sync_reset) begin
            state_nxt = S_IDLE;
            done      = 1'b0;
        end
    end

    // Grant, payload latch, timeout counter and pointer rotation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr         <= '0;
            gnt         <= '0;
            tmo_cnt     <= '0;
            lat_rd_en   <= 1'b0;
            lat_wr_en   <= 1'b0;
            lat_addr    <= '0;
            lat_wr_data <= '0;
        end else if (sync_reset) begin
            ptr         <= '0;
            gnt         <= '0;
            tmo_cnt     <= '0;
            lat_rd_en   <= 1'b0;
            lat_wr_en   <= 1'b0;
            lat_addr    <= '0;
            lat_wr_data <= '0;
        end else begin
            if (accept) begin
                gnt         <= winner;
                tmo_cnt     <= '0;
                lat_rd_en   <= bus.mst__arb__rd_en[winner];
                lat_wr_en   <= bus.mst__arb__wr_en[winner];
                lat_addr    <= bus.mst__arb__addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                lat_wr_data <= bus.mst__arb__wr_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            end else if (busy && (tmo_cnt != TMO_LAST)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (done) begin
                ptr <= (gnt == MST_LAST) ? '0 : gnt + 1'b1;
            end
        end
    end

    // Output decode; slave payload is only driven while an access is live.
    always_comb begin
        bus.arb__mst__req_rdy = '0;
        bus.arb__mst__ack_vld = '0;
        bus.arb__mst__ack_err = 1'b0;
        bus.arb__mst__rd_data = '0;
        bus.arb__slv__req_vld = (state == S_REQ);
        bus.arb__slv__rd_en   = 1'b0;
        bus.arb__slv__wr_en   = 1'b0;
        bus.arb__slv__addr    = '0;
        bus.arb__slv__wr_data = '0;
        bus.arb__slv__ack_rdy = ack_path ? ack_rdy_gnt : 1'b0;
        if (accept) begin
            bus.arb__mst__req_rdy[winner] = 1'b1;
        end
        if (!sync_reset) begin
            if (ack_path && bus.slv__arb__ack_vld) begin
                bus.arb__mst__ack_vld[gnt] = 1'b1;
                bus.arb__mst__rd_data      = bus.slv__arb__rd_data;
            end
            if (state == S_TMO) begin
                bus.arb__mst__ack_vld[gnt] = 1'b1;
                bus.arb__mst__ack_err      = 1'b1;
            end
        end
        if (busy) begin
            bus.arb__slv__rd_en   = lat_rd_en;
            bus.arb__slv__wr_en   = lat_wr_en;
            bus.arb__slv__addr    = lat_addr;
            bus.arb__slv__wr_data = lat_wr_data;
        end
    end
endmodule
